button_conditioner: RTL and testbench

//  Synchronises and debounces the raw board push-buttons (BUTTON_UP, BUTTON_DOWN) before they reach topEntity.

---
 rtl/button_conditioner.sv | 76 +++++++
 tb/tb_button_conditioner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync + debounce with press/release strobes; BUTTON_CONDITIONER_AUTOREPEAT_EN adds held-button repeats
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit INVERT_IN       = 1'b0,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic             CLK_25MHZ,
  input  logic             RESET_N,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [N_BTN-1:0] IDLE = {N_BTN{INVERT_IN}};
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
`endif
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES>=2, REPEAT_DELAY>=1, REPEAT_PERIOD>=1 required");
  end
  logic [N_BTN-1:0] sync1, sync2, y;
  always_ff @(posedge CLK_25MHZ or negedge RESET_N)
    if (!RESET_N) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= BTN_IN;
      sync2 <= sync1;
    end
  assign y = sync2 ^ IDLE;
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic lvl, prs, rls, accept, rep_fire;
    assign accept = (y[g] != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    logic [RW-1:0] rcnt;
    logic rep;
    // rep selects the first-repeat delay versus the steady repeat period
    assign rep_fire = lvl && !accept && (rcnt == (rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));
    always_ff @(posedge CLK_25MHZ or negedge RESET_N)
      if (!RESET_N) begin
        rcnt <= '0;
        rep  <= 1'b0;
      end else if (!lvl || accept) begin
        rcnt <= '0;
        rep  <= 1'b0;
      end else if (rep_fire) begin
        rcnt <= '0;
        rep  <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
`else
    assign rep_fire = 1'b0;
`endif
    always_ff @(posedge CLK_25MHZ or negedge RESET_N)
      if (!RESET_N) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        cnt <= (y[g] == lvl || accept) ? '0 : cnt + 1'b1;
        lvl <= accept ? y[g] : lvl;
        prs <= (accept && y[g]) || rep_fire;
        rls <= accept && !y[g];
      end
    assign BTN_LEVEL[g]   = lvl;
    assign BTN_PRESS[g]   = prs;
    assign BTN_RELEASE[g] = rls;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized checks against a behavioural debounce/repeat model
module tb_button_conditioner;
  localparam int D = 4;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int RD = 8;
  localparam int RP = 3;
  localparam int EXP_STROBES = 6;
`else
  localparam int EXP_STROBES = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] btn = 2'b11;
  logic [1:0] lvl, prs, rls;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  button_conditioner #(
    .N_BTN(2), .DEBOUNCE_CYCLES(4), .INVERT_IN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .CLK_25MHZ(clk), .RESET_N(rst_n), .BTN_IN(btn),
    .BTN_LEVEL(lvl), .BTN_PRESS(prs), .BTN_RELEASE(rls)
  );
  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask
  // model: a sample reaches the debouncer two edges after it is taken; D consecutive differing samples are accepted
  bit [1:0] m_lvl, m_prs, m_rls;
  bit d1[2], d2[2];
  int run[2];
  int cyc = 0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  int acc[2];
`endif
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_lvl = '0; m_prs = '0; m_rls = '0;
      for (int c = 0; c < 2; c++) begin
        d1[c] = 1'b0; d2[c] = 1'b0; run[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit yv;
        yv = d2[c];
        d2[c] = d1[c];
        d1[c] = btn[c];
        m_prs[c] = 1'b0;
        m_rls[c] = 1'b0;
        run[c] = (yv != m_lvl[c]) ? run[c] + 1 : 0;
        if (run[c] == D) begin
          m_lvl[c] = yv;
          run[c] = 0;
          if (yv) m_prs[c] = 1'b1;
          else m_rls[c] = 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          acc[c] = cyc;
        end else if (m_lvl[c] && (cyc - acc[c]) >= RD && ((cyc - acc[c] - RD) % RP) == 0) begin
          m_prs[c] = 1'b1;
`endif
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("level", lvl, rst_n ? m_lvl : 2'b00);
    chk("press", prs, rst_n ? m_prs : 2'b00);
    chk("release", rls, rst_n ? m_rls : 2'b00);
    chk("press_and_release", prs & rls, 2'b00);
  end
  initial begin
    int np;
    btn = 2'b11;
    rst_n = 1'b0;
    step(3);
    chk("t1_in_reset", lvl | prs | rls, 2'b00);
    rst_n = 1'b1;
    step(5);
    chk("t1_lvl_e5", lvl, 2'b00);
    chk("t1_prs_e5", prs, 2'b00);
    step(1);
    chk("t1_lvl_e6", lvl, 2'b11);
    chk("t1_prs_e6", prs, 2'b11);
    np = 1;
    for (int j = 1; j <= 20; j++) begin
      step(1);
      if (j == 1) chk("t1_prs_1cyc", prs, 2'b00);
      np += int'(prs[0]);
    end
    chk_int("t6_strobe_count", np, EXP_STROBES);
    btn = 2'b00;
    step(5);
    chk("t4_rls_e4", rls, 2'b00);
    chk("t4_lvl_e4", lvl, 2'b11);
    step(1);
    chk("t4_rls_e5", rls, 2'b11);
    chk("t4_prs_e5", prs, 2'b00);
    chk("t4_lvl_e5", lvl, 2'b00);
    step(1);
    chk("t4_rls_1cyc", rls, 2'b00);
    step(3);
    btn = 2'b01;
    step(5);
    chk("t2_lvl_e4", lvl, 2'b00);
    step(1);
    chk("t2_lvl_e5", lvl, 2'b01);
    chk("t2_prs_e5", prs, 2'b01);
    step(1);
    chk("t2_prs_1cyc", prs, 2'b00);
    chk("t2_lvl_hold", lvl, 2'b01);
    btn = 2'b00;
    step(8);
    for (int b = 0; b < 5; b++) begin
      btn = 2'b01;
      step(3);
      btn = 2'b00;
      step(1);
      chk("t3_glitch_lvl", lvl, 2'b00);
    end
    step(6);
    chk("t3_glitch_final", lvl, 2'b00);
    btn = 2'b01;
    step(8);
    chk("t5_pre_lvl", lvl, 2'b01);
    btn = 2'b11;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("t5_async_lvl", lvl, 2'b00);
    chk("t5_async_strobes", prs | rls, 2'b00);
    step(2);
    rst_n = 1'b1;
    step(5);
    chk("t5_restart_e5", lvl, 2'b00);
    step(1);
    chk("t5_restart_lvl", lvl, 2'b11);
    chk("t5_restart_prs", prs, 2'b11);
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, 5) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
